// File: rtl/instruction_fetch.sv
// Instruction fetch stage: owns the PC, drives instruction memory and fills the IF/ID register.
// Jumps are resolved locally by predecode; branch redirects come from a later stage.
module instruction_fetch #(
  parameter int unsigned       ADDR_W    = 10,
  parameter int unsigned       DATA_W    = 32,
  parameter int unsigned       MEM_DEPTH = 81,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0,
  parameter logic [5:0]        JUMP_OP   = 6'b010100
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  output logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] instrucao,
  output logic [DATA_W-1:0] if_instr,
  output logic [ADDR_W-1:0] if_pc,
  output logic [ADDR_W-1:0] if_pc_plus1,
  output logic              if_valid,
  output logic              halted
);

  localparam logic [31:0]       Depth32 = 32'(MEM_DEPTH);
  localparam logic [ADDR_W-1:0] LastPc  = ADDR_W'(MEM_DEPTH - 1);

  typedef enum logic [1:0] {
    StBoot,
    StRun,
    StHalt
  } state_e;

  state_e state_q, state_d;

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0] ipc_q, ipc_d;
  logic [ADDR_W-1:0] ipc1_q, ipc1_d;
  logic              valid_q, valid_d;

  logic              is_jump;
  logic [25:0]       jump_tgt;
  logic              jump_ok;
  logic              branch_ok;
  logic              at_last;
  logic [ADDR_W-1:0] pc_plus1;

  // Targets are range-checked at full width so high jump bits cannot alias into range.
  assign is_jump   = (instrucao[31:26] == JUMP_OP);
  assign jump_tgt  = instrucao[25:0];
  assign jump_ok   = (32'(jump_tgt) < Depth32);
  assign branch_ok = (32'(branch_target) < Depth32);
  assign at_last   = (pc_q == LastPc);
  assign pc_plus1  = pc_q + ADDR_W'(1);

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= StBoot;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StBoot: state_d = StRun;
      StRun: begin
        if (branch_taken) begin
          if (!branch_ok) state_d = StHalt;
        end else if (!stall) begin
          if (is_jump) begin
            if (!jump_ok) state_d = StHalt;
          end else if (at_last) begin
            state_d = StHalt;
          end
        end
      end
      StHalt: begin
        if (branch_taken && branch_ok) state_d = StRun;
      end
      default: state_d = StBoot;
    endcase
  end

  // Output logic
  always_comb begin
    halted = (state_q == StHalt);
  end

  // PC and IF/ID next values
  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    ipc_d   = ipc_q;
    ipc1_d  = ipc1_q;
    valid_d = valid_q;
    unique case (state_q)
      StBoot: valid_d = 1'b0;
      StRun: begin
        if (branch_taken) begin
          valid_d = 1'b0;
          if (branch_ok) pc_d = branch_target;
        end else if (!stall) begin
          instr_d = instrucao;
          ipc_d   = pc_q;
          ipc1_d  = pc_plus1;
          valid_d = 1'b1;
          if (is_jump) begin
            if (jump_ok) pc_d = jump_tgt[ADDR_W-1:0];
          end else if (!at_last) begin
            pc_d = pc_plus1;
          end
        end
      end
      StHalt: begin
        valid_d = 1'b0;
        if (branch_taken && branch_ok) pc_d = branch_target;
      end
      default: valid_d = 1'b0;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc_q    <= RESET_PC;
      instr_q <= '0;
      ipc_q   <= '0;
      ipc1_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      ipc_q   <= ipc_d;
      ipc1_q  <= ipc1_d;
      valid_q <= valid_d;
    end
  end

  assign address     = pc_q;
  assign if_instr    = instr_q;
  assign if_pc       = ipc_q;
  assign if_pc_plus1 = ipc1_q;
  assign if_valid    = valid_q;

endmodule
